// File: rtl/adler_pkg.sv
// Shared constants and FSM encoding for the Adler-32 stream engine.
// The optional seeding feature is enabled with the ADLER_SEED_EN macro.
package adler_pkg;
    localparam logic [15:0] ADLER_MOD   = 16'd65521;
    localparam logic [15:0] A_INIT      = 16'd1;
    localparam logic [15:0] B_INIT      = 16'd0;
    // 2^16 mod 65521, used to fold the bits above bit 15 back in
    localparam logic [7:0]  FOLD_FACTOR = 8'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adler_mod_reduce.sv
// Combinational modulo-65521 reduction for sums below 2^20 whose folded value
// stays under twice the modulus (true for both the A and B beat sums).
module adler_mod_reduce
    import adler_pkg::*;
(
    input  logic [19:0] value,
    output logic [15:0] result
);
    logic [7:0]  fold_hi;
    logic [16:0] folded;
    logic [16:0] diff;

    always_comb begin
        fold_hi = {4'd0, value[19:16]} * FOLD_FACTOR;
        folded  = {1'b0, value[15:0]} + {9'd0, fold_hi};
        diff    = folded - {1'b0, ADLER_MOD};
        result  = (folded >= {1'b0, ADLER_MOD}) ? diff[15:0] : folded[15:0];
    end
endmodule

// File: rtl/adler32_stream.sv
// Adler-32 engine taking 1, 2 or 4 bytes per clock; checksum one cycle after the last beat.
// Define ADLER_SEED_EN to add seed/seed_load for continuing a previous checksum.
module adler32_stream
    import adler_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1,
    localparam int CNT_W = $clog2(BYTES_PER_CYCLE + 1)
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         data_valid,
    input  logic [8*BYTES_PER_CYCLE-1:0] data,
    input  logic                         last_data,
    input  logic [CNT_W-1:0]             last_bytes,
`ifdef ADLER_SEED_EN
    input  logic                         seed_load,
    input  logic [31:0]                  seed,
`endif
    output logic                         busy,
    output logic                         checksum_valid,
    output logic [31:0]                  checksum
);
    localparam int         N     = BYTES_PER_CYCLE;
    localparam logic [2:0] N_CNT = 3'(N);

    if (N != 1 && N != 2 && N != 4) begin : g_bad_width
        $error("adler32_stream: BYTES_PER_CYCLE must be 1, 2 or 4");
    end

    state_t      state;
    logic [15:0] sum_a;
    logic [15:0] sum_b;
    logic [15:0] a_next;
    logic [15:0] b_next;
    logic [2:0]  lb_ext;
    logic [2:0]  beat_cnt;
    logic [10:0] byte_sum;
    logic [11:0] weight_sum;
    logic [16:0] a_raw;
    logic [19:0] b_raw;

    // Over-long last_bytes is clamped rather than trusted.
    always_comb begin
        lb_ext   = 3'(last_bytes);
        beat_cnt = N_CNT;
        if (last_data)
            beat_cnt = (lb_ext > N_CNT) ? N_CNT : lb_ext;
    end

    // Byte i is seen by B (k - i) times within a k-byte beat.
    always_comb begin
        byte_sum   = '0;
        weight_sum = '0;
        for (int i = 0; i < N; i++) begin
            if (3'(i) < beat_cnt) begin
                byte_sum   = byte_sum + 11'(data[8*i +: 8]);
                weight_sum = weight_sum
                           + 12'(data[8*i +: 8]) * 12'(beat_cnt - 3'(i));
            end
        end
        a_raw = 17'(sum_a) + 17'(byte_sum);
        b_raw = 20'(sum_b) + 20'(sum_a) * 20'(beat_cnt) + 20'(weight_sum);
    end

    adler_mod_reduce u_reduce_a (
        .value  ({3'd0, a_raw}),
        .result (a_next)
    );

    adler_mod_reduce u_reduce_b (
        .value  (b_raw),
        .result (b_next)
    );

    // The running sums are re-initialised on the last beat itself, so a beat
    // arriving in DONE already starts from 1/0 without any extra muxing.
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            sum_a    <= A_INIT;
            sum_b    <= B_INIT;
            checksum <= '0;
        end
`ifdef ADLER_SEED_EN
        else if (seed_load && state != RUN) begin
            state <= IDLE;
            sum_a <= seed[15:0];
            sum_b <= seed[31:16];
        end
`endif
        else if (data_valid) begin
            if (last_data) begin
                state    <= DONE;
                sum_a    <= A_INIT;
                sum_b    <= B_INIT;
                checksum <= {b_next, a_next};
            end else begin
                state <= RUN;
                sum_a <= a_next;
                sum_b <= b_next;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

    always_comb begin
        busy           = (state == RUN);
        checksum_valid = (state == DONE);
    end
endmodule

// File: tb/tb_adler32_stream.sv
// Bench for adler32_stream: one instance each of 1, 2 and 4 bytes per cycle, table
// vectors plus hand sequences, with a scoreboard checking value and latency.
module tb_adler32_stream;
    typedef struct {
        logic [31:0] value;
        int          cyc;
    } exp_t;

    typedef struct {
        int          dut;
        string       msg;
        int          lb_force;
        logic [31:0] exp;
    } vec_t;

    logic             clock = 1'b0;
    logic             rst;
    logic [2:0]       dv;
    logic [2:0]       lst;
    logic [7:0]       d1;
    logic [15:0]      d2;
    logic [31:0]      d4;
    logic [0:0]       lb1;
    logic [1:0]       lb2;
    logic [2:0]       lb4;
    logic [2:0]       seed_load;
    logic [31:0]      seed;
    logic [2:0]       bz;
    logic [2:0]       cv;
    logic [2:0][31:0] cs;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   range_viol = 0;
    exp_t sb [3][$];
    exp_t mon_e;
    vec_t vecs [10];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    adler32_stream #(.BYTES_PER_CYCLE(1)) dut1 (
        .clock(clock), .rst(rst), .data_valid(dv[0]), .data(d1), .last_data(lst[0]),
        .last_bytes(lb1),
`ifdef ADLER_SEED_EN
        .seed_load(seed_load[0]), .seed(seed),
`endif
        .busy(bz[0]), .checksum_valid(cv[0]), .checksum(cs[0]));

    adler32_stream #(.BYTES_PER_CYCLE(2)) dut2 (
        .clock(clock), .rst(rst), .data_valid(dv[1]), .data(d2), .last_data(lst[1]),
        .last_bytes(lb2),
`ifdef ADLER_SEED_EN
        .seed_load(seed_load[1]), .seed(seed),
`endif
        .busy(bz[1]), .checksum_valid(cv[1]), .checksum(cs[1]));

    adler32_stream #(.BYTES_PER_CYCLE(4)) dut4 (
        .clock(clock), .rst(rst), .data_valid(dv[2]), .data(d4), .last_data(lst[2]),
        .last_bytes(lb4),
`ifdef ADLER_SEED_EN
        .seed_load(seed_load[2]), .seed(seed),
`endif
        .busy(bz[2]), .checksum_valid(cv[2]), .checksum(cs[2]));

    // Scoreboard: each expected checksum must appear exactly at its cycle.
    always @(negedge clock) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (cv[i]) begin
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid dut%0d got %h at cyc %0d", i, cs[i], cyc);
                    end else begin
                        mon_e = sb[i].pop_front();
                        if (cs[i] !== mon_e.value || cyc != mon_e.cyc) begin
                            errors++;
                            $display("FAIL checksum dut%0d got %h at cyc %0d, want %h at cyc %0d",
                                     i, cs[i], cyc, mon_e.value, mon_e.cyc);
                        end
                    end
                end else if (sb[i].size() > 0 && cyc >= sb[i][0].cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid dut%0d want %h at cyc %0d", i, sb[i][0].value, sb[i][0].cyc);
                    void'(sb[i].pop_front());
                end
            end
        end
        if (!rst && (dut4.sum_a > 16'd65520 || dut4.sum_b > 16'd65520))
            range_viol++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic idle();
        dv  = '0;
        lst = '0;
    endtask

    task automatic drive_beat(input int i, input logic [31:0] w, input logic last, input int lb);
        dv     = '0;
        lst    = '0;
        dv[i]  = 1'b1;
        lst[i] = last;
        case (i)
            0:       begin d1 = w[7:0];  lb1 = 1'(lb); end
            1:       begin d2 = w[15:0]; lb2 = 2'(lb); end
            default: begin d4 = w;       lb4 = 3'(lb); end
        endcase
    endtask

    // Splits a message into beats; the expected result is queued with the cycle
    // in which checksum_valid must be seen.
    task automatic send_msg(input int i, input string s, input int lb_force, input logic [31:0] exp);
        int n, beats, len, cnt;
        logic [31:0] w;
        n     = 1 << i;
        len   = s.len();
        beats = (len == 0) ? 1 : (len + n - 1) / n;
        for (int b = 0; b < beats; b++) begin
            w   = '0;
            cnt = 0;
            for (int j = 0; j < n; j++) begin
                if (b * n + j < len) begin
                    w[8*j +: 8] = s[b*n + j];
                    cnt++;
                end
            end
            if (b == beats - 1) sb[i].push_back('{exp, cyc + 1});
            drive_beat(i, w, b == beats - 1, (lb_force >= 0) ? lb_force : cnt);
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), 32'(bz[i]), 32'd0);
            chk($sformatf("%s_valid%0d", tag, i), 32'(cv[i]), 32'd0);
            chk($sformatf("%s_checksum%0d", tag, i), cs[i], 32'h0);
        end
    endtask

    initial begin
        logic [15:0] ma, mb;
        vecs[0] = '{0, "abc",       -1, 32'h024D0127};
        vecs[1] = '{2, "Wikipedia", -1, 32'h11E60398};
        vecs[2] = '{1, "Wikipedia", -1, 32'h11E60398};
        vecs[3] = '{0, "",          -1, 32'h00000001};
        vecs[4] = '{1, "",          -1, 32'h00000001};
        vecs[5] = '{2, "",          -1, 32'h00000001};
        vecs[6] = '{1, "ab",         3, 32'h012600C4};
        vecs[7] = '{2, "abcd",       7, 32'h03D8018B};
        vecs[8] = '{2, "abc",       -1, 32'h024D0127};
        vecs[9] = '{0, "a",         -1, 32'h00620062};

        rst = 1'b1; dv = '0; lst = '0; seed_load = '0; seed = '0;
        d1 = '0; d2 = '0; d4 = '0; lb1 = '0; lb2 = '0; lb4 = '0;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock); #1;
        rst = 1'b0;
        wait_cycles(2);

        for (int v = 0; v < 10; v++) begin
            send_msg(vecs[v].dut, vecs[v].msg, vecs[v].lb_force, vecs[v].exp);
            idle();
            wait_cycles(3);
        end

        // Back-to-back: each new message starts in the DONE cycle of the previous one.
        send_msg(0, "", -1, 32'h00000001);
        send_msg(0, "abc", -1, 32'h024D0127);
        send_msg(0, "abc", -1, 32'h024D0127);
        send_msg(2, "Wikipedia", -1, 32'h11E60398);
        send_msg(2, "abc", -1, 32'h024D0127);
        idle();
        wait_cycles(3);

        // Stalled message: busy holds across idle cycles in RUN.
        drive_beat(2, "ikiW", 1'b0, 4);
        @(posedge clock); #1;
        idle();
        @(negedge clock);
        chk("busy_run", 32'(bz[2]), 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("busy_stall", 32'(bz[2]), 32'd1);
        @(posedge clock); #1;
        drive_beat(2, "idep", 1'b0, 4);
        @(posedge clock); #1;
        sb[2].push_back('{32'h11E60398, cyc + 1});
        drive_beat(2, {24'd0, 8'h61}, 1'b1, 1);
        @(posedge clock); #1;
        idle();
        wait_cycles(2);
        @(negedge clock);
        chk("busy_after_done", 32'(bz[2]), 32'd0);
        @(posedge clock); #1;

        // Reset mid-message discards the partial sums.
        drive_beat(2, "ikiW", 1'b0, 4);
        @(posedge clock); #1;
        drive_beat(2, "idep", 1'b0, 4);
        @(posedge clock); #1;
        idle();
        rst = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_reset_outputs("midrst");
        @(posedge clock); #1;
        rst = 1'b0;
        send_msg(2, "abc", -1, 32'h024D0127);
        idle();
        wait_cycles(3);

        // Long continuous stream of 0xFF against a per-byte software model.
        ma = 16'd1; mb = 16'd0;
        for (int b = 0; b < 4000; b++) begin
            for (int j = 0; j < 4; j++) begin
                ma = 16'((32'(ma) + 32'd255) % 32'd65521);
                mb = 16'((32'(mb) + 32'(ma)) % 32'd65521);
            end
            if (b == 3999) sb[2].push_back('{{mb, ma}, cyc + 1});
            drive_beat(2, 32'hFFFF_FFFF, b == 3999, 4);
            @(posedge clock); #1;
        end
        idle();
        wait_cycles(3);

`ifdef ADLER_SEED_EN
        seed_load[0] = 1'b1;
        seed = 32'h024D0127;
        @(posedge clock); #1;
        seed_load = '0;
        send_msg(0, "d", -1, 32'h03D8018B);
        idle();
        wait_cycles(2);
        send_msg(0, "abc", -1, 32'h024D0127);
        idle();
        wait_cycles(3);
`endif

        wait_cycles(4);
        chk("pending_results", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
        chk("range_violations", 32'(range_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adler32_stream.md
# adler32_stream

Parametrised Adler-32 checksum engine that accepts 1, 2 or 4 bytes per clock and produces the 32-bit checksum one cycle after the last beat of a message. It supersedes the single-byte checksum datapath. It sits on the byte-stream side of the design, between the data source and whatever consumes the checksum (framing, compare logic). It supports back-to-back messages, partial final beats and, optionally, seeding from a previous checksum.

## Interface
- BYTES_PER_CYCLE, 1, bytes accepted per beat; legal values 1, 2, 4 (anything else is an elaboration error)
- CNT_W, $clog2(BYTES_PER_CYCLE+1), width of last_bytes (derived, not overridden)

Ports:
- clock  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_valid  in  1  beat qualifier
- data  in  8*BYTES_PER_CYCLE  byte 0 = data[7:0] is first in stream order
- last_data  in  1  this beat ends the message (qualified by data_valid)
- last_bytes  in  CNT_W  valid bytes on the last beat, 0..BYTES_PER_CYCLE; ignored on non-last beats
- seed_load  in  1  load seed as running state (only with ADLER_SEED_EN)
- seed  in  32  {B,A} seed value (only with ADLER_SEED_EN)
- busy  out  1  message in progress (≥1 beat accepted, last not yet seen)
- checksum_valid  out  1  one-cycle pulse, checksum valid
- checksum  out  32  {B[15:0], A[15:0]}

## Operation
- Running state A (16 b), B (16 b); idle/reset values A=1, B=0.
- Always ready: every cycle with data_valid=1 is an accepted beat.
- Beat with k valid bytes d0..d(k-1): k=BYTES_PER_CYCLE on non-last beats, k=last_bytes on last beat.
  - A' = (A + Σdi) mod 65521.
  - B' = (B + k·A + Σ(k−i)·di) mod 65521.
- Width rules:
  - A sum computed in 17 b, max 66540 < 2·65521; one conditional subtract.
  - B sum computed in 20 b, max 330150; reduce by fold x → 15·x[19:16] + x[15:0], then one conditional subtract of 65521.
  - Result always in 0..65520.
- FSM states:
  - IDLE → RUN on an accepted non-last beat.
  - IDLE/RUN → DONE on an accepted last beat.
  - RUN stays RUN on a non-last beat.
  - DONE lasts one cycle: checksum_valid=1, then A/B return to 1/0.
  - An accepted beat during DONE starts the next message from A=1, B=0 (back-to-back, no bubble).
- last_bytes=0 on a last beat: zero-byte contribution; a lone such beat yields 0x00000001.
- last_bytes > BYTES_PER_CYCLE: clamped to BYTES_PER_CYCLE.
- checksum holds its last value until the next DONE; busy=1 in RUN only.

## Timing
- Reset: A=1, B=0, state IDLE, busy=0, checksum_valid=0, checksum=0x00000000. Reset mid-message discards all progress.
- Latency: the last beat accepted at edge n gives checksum_valid=1 and final checksum in the cycle after edge n.
- Throughput: BYTES_PER_CYCLE bytes/cycle sustained, including across message boundaries.
- rst has priority over seed_load, which has priority over data_valid in the same cycle.
- data_valid=0 in RUN: state holds, busy stays 1.

## Configuration
- ADLER_SEED_EN defined:
  - seed_load=1 (while not busy) sets A=seed[15:0], B=seed[31:16] for the next message.
  - seed_load while busy is ignored.
  - The seed applies to exactly one message; afterwards A/B revert to 1/0.
- Not defined: seed and seed_load ports are absent; every message starts from 1/0.

## Structure
- Package adler_pkg:
  - ADLER_MOD = 16'd65521, A_INIT = 16'd1, B_INIT = 16'd0.
  - FSM state enum (IDLE, RUN, DONE).
  - Constant fold factor 15.
- Sub-module adler_mod_reduce: combinational; 20 b in, 16 b out; fold + conditional subtract. Instantiated once for A and once for B.
- Top holds the FSM, the weighted-sum tree and the state registers.

## Test plan
- N=1, "abc" (0x61,0x62,0x63), last on third beat → checksum_valid pulse one cycle later, checksum=0x024D0127.
- N=4, "Wikipedia" as beats of 4,4,1 bytes (last_bytes=1) → 0x11E60398; repeat with N=2 (beats 2,2,2,2,1) → same value.
- Single beat, last_data=1, last_bytes=0 → 0x00000001; back-to-back "abc" in the DONE cycle → 0x024D0127 with no gap.
- 4000 beats of 0xFF, N=4, continuous → matches the software model; A and B never exceed 65520 (assertion).
- rst pulsed after two beats of "Wikipedia", then "abc" → 0x024D0127; all outputs at reset values during rst.
- ADLER_SEED_EN: seed=0x024D0127, then single byte 0x64 → 0x03D8018B; the following "abc" without seed → 0x024D0127.
